// File: rtl/flag_scheduler_pkg.sv
// flag_scheduler_pkg: shared types and the round-robin pick helper for flag_scheduler.
package flag_scheduler_pkg;
  localparam int N_MAX = 16;
  typedef enum logic {FS_IDLE, FS_OFFER} fs_state_t;
  // Unused high bits must be zero so the 4-bit wrap behaves as a wrap at N.
  function automatic logic [3:0] rr_pick(input logic [N_MAX-1:0] pending, input logic [3:0] ptr);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = N_MAX - 1; k >= 0; k--) begin
      idx = ptr + 4'(k);
      if (pending[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/flag_cell.sv
// flag_cell: sticky event flag with set-over-clear priority; optional lost-event bit under FLAG_SCHEDULER_OVF_EN.
module flag_cell (
  input  logic clk,
  input  logic reset,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
`ifdef FLAG_SCHEDULER_OVF_EN
  ,
  output logic ovf_o
`endif
);
  logic flag_q, flag_d;
  assign flag_d = set_i ? 1'b1 : clr_i ? 1'b0 : flag_q;
  always_ff @(posedge clk) flag_q <= reset ? 1'b0 : flag_d;
  assign flag_o = flag_q;
`ifdef FLAG_SCHEDULER_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | (set_i & flag_q & ~clr_i);
  always_ff @(posedge clk) ovf_q <= reset ? 1'b0 : ovf_d;
  assign ovf_o = ovf_q;
`endif
endmodule

// File: rtl/flag_scheduler.sv
// flag_scheduler: round-robin valid/ready scheduler over N sticky event flags.
// Defining FLAG_SCHEDULER_OVF_EN adds the sticky lost-event output ovf_o.
module flag_scheduler
  import flag_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   set_i,
  output logic [N-1:0]   pending_o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [IDW-1:0] out_id,
  output logic           busy
`ifdef FLAG_SCHEDULER_OVF_EN
  ,
  output logic [N-1:0]   ovf_o
`endif
);
  fs_state_t      state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d;
  logic [3:0]     pick;
  logic [N-1:0]   clr;
  logic           accept;
  assign accept = out_valid & out_ready;
  assign pick   = rr_pick(N_MAX'(pending_o), 4'(ptr_q));
  for (genvar i = 0; i < N; i++) begin : g_cell
    assign clr[i] = accept && id_q == IDW'(i);
    flag_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .set_i (set_i[i]),
      .clr_i (clr[i]),
      .flag_o(pending_o[i])
`ifdef FLAG_SCHEDULER_OVF_EN
      ,
      .ovf_o (ovf_o[i])
`endif
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
    end
  end
  // The offered index is latched only when leaving IDLE, so sets during OFFER cannot move it.
  always_comb begin
    state_d = state_q == FS_IDLE ? (|pending_o ? FS_OFFER : FS_IDLE) : (out_ready ? FS_IDLE : FS_OFFER);
    id_d    = (state_q == FS_IDLE && |pending_o) ? IDW'(pick) : id_q;
    ptr_d   = accept ? ((id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1)) : ptr_q;
  end
  always_comb begin
    out_valid = state_q == FS_OFFER;
    out_id    = id_q;
    busy      = |pending_o | out_valid;
  end
endmodule

// File: tb/tb_flag_scheduler.sv
// tb_flag_scheduler: directed stimulus, per-cycle reference model compare, plus hand-computed literal checks.
module tb_flag_scheduler;
  localparam int N = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] set_i = 4'b1111;
  logic out_ready = 1'b0;
  logic [N-1:0] pending_o;
  logic out_valid;
  logic [IDW-1:0] out_id;
  logic busy;
`ifdef FLAG_SCHEDULER_OVF_EN
  logic [N-1:0] ovf_o;
`endif
  int checks = 0;
  int failures = 0;

  flag_scheduler #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .set_i    (set_i),
    .pending_o(pending_o),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .busy     (busy)
`ifdef FLAG_SCHEDULER_OVF_EN
    ,
    .ovf_o    (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: flags as a bit array, the offer as (valid, id), pointer as a plain integer.
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;
  bit m_valid;
  int m_id;
  int m_ptr;
  bit armed = 1'b0;

  always @(posedge clk) begin
    bit [N-1:0] nxt;
    bit acc;
    bit found;
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0; m_ptr = 0;
    end else begin
      acc = m_valid && out_ready;
      for (int i = 0; i < N; i++) begin
        nxt[i] = set_i[i] ? 1'b1 : (acc && m_id == i) ? 1'b0 : m_pend[i];
        if (set_i[i] && m_pend[i] && !(acc && m_id == i)) m_ovf[i] = 1'b1;
      end
      if (acc) begin
        m_valid = 0;
        m_ptr = (m_id + 1) % N;
      end else if (!m_valid && m_pend != 0) begin
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && m_pend[(m_ptr + k) % N]) begin
            found = 1;
            m_id = (m_ptr + k) % N;
          end
        m_valid = 1;
      end
      m_pend = nxt;
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_pending", 32'(pending_o), 32'(m_pend));
      chk("model_valid", 32'(out_valid), 32'(m_valid));
      chk("model_id", 32'(out_id), 32'(m_id));
      chk("model_busy", 32'(busy), 32'(m_pend != 0 || m_valid));
`ifdef FLAG_SCHEDULER_OVF_EN
      chk("model_ovf", 32'(ovf_o), 32'(m_ovf));
`endif
    end
  end

  task automatic drive(input logic [N-1:0] s, input logic r);
    set_i = s;
    out_ready = r;
    @(negedge clk);
  endtask

  initial begin
    // reset dominance
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_pending", 32'(pending_o), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    chk("rst_after_pending", 32'(pending_o), 0);
    chk("rst_after_busy", 32'(busy), 0);
    chk("rst_after_id", 32'(out_id), 0);
    // single event
    drive(4'b0100, 1'b1);
    chk("single_pend_c1", 32'(pending_o), 32'h4);
    chk("single_valid_c1", 32'(out_valid), 0);
    drive(4'b0000, 1'b1);
    chk("single_valid_c2", 32'(out_valid), 1);
    chk("single_id_c2", 32'(out_id), 2);
    drive(4'b0000, 1'b1);
    chk("single_pend_c3", 32'(pending_o), 0);
    chk("single_valid_c3", 32'(out_valid), 0);
    // round-robin from ptr=3
    drive(4'b0000, 1'b0);
    drive(4'b1111, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      chk("rr_valid", 32'(out_valid), 32'(c % 2 == 0));
      if (c % 2 == 0) chk("rr_id", 32'(out_id), 32'((c / 2 + 2) % 4));
      drive(4'b0000, 1'b1);
    end
    chk("rr_busy_c9", 32'(busy), 0);
    // backpressure
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    chk("bp_valid_c2", 32'(out_valid), 1);
    chk("bp_id_c2", 32'(out_id), 3);
    drive(4'b0001, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0001, 1'b0);
    drive(4'b0000, 1'b0);
    chk("bp_valid_held", 32'(out_valid), 1);
    chk("bp_id_held", 32'(out_id), 3);
    chk("bp_pend", 32'(pending_o), 32'h9);
    drive(4'b0000, 1'b1);
    chk("bp_after_accept", 32'(out_valid), 0);
    drive(4'b0000, 1'b1);
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_id", 32'(out_id), 0);
`ifdef FLAG_SCHEDULER_OVF_EN
    chk("ovf_set", 32'(ovf_o), 32'h1);
`endif
    drive(4'b0000, 1'b1);
`ifdef FLAG_SCHEDULER_OVF_EN
    chk("ovf_held", 32'(ovf_o), 32'h1);
`endif
    // set/clear collision on flag 1
    drive(4'b0110, 1'b0);
    drive(4'b0000, 1'b0);
    chk("col_id", 32'(out_id), 1);
    drive(4'b1011, 1'b1);
    chk("col_pend", 32'(pending_o), 32'hf);
    chk("col_valid", 32'(out_valid), 0);
    for (int j = 0; j < 4; j++) begin
      drive(4'b0000, 1'b1);
      chk("col_order", 32'(out_id), 32'((j + 2) % 4));
      drive(4'b0000, 1'b1);
    end
    chk("col_busy", 32'(busy), 0);
    // reset mid-offer
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    chk("mid_valid", 32'(out_valid), 1);
    reset = 1'b1;
    drive(4'b0000, 1'b1);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_pend", 32'(pending_o), 0);
`ifdef FLAG_SCHEDULER_OVF_EN
    chk("ovf_rst", 32'(ovf_o), 0);
`endif
    reset = 1'b0;
    drive(4'b0000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
